// File: rtl/keypad_scan_entry.sv
//==========================================================================
// Module   : keypad_scan_entry
// Desc     : 4x4 hex keypad scanner. Rotating active-low column strobe,
//            synchronized active-low row returns, press/release debounce,
//            key decode and a 4-nibble shift-in entry register HEX3..HEX0.
// Options  : KEY_REPEAT_EN - auto-repeat while a key stays held
// Revision : 1.0  initial release
//==========================================================================
`default_nettype none

module keypad_scan_entry #(
   parameter int TICK_CYCLES    = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0
);

   localparam int               DIV_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DIV_W-1:0] TICK_LAST  = DIV_W'(TICK_CYCLES - 1);
   localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);

   localparam logic [1:0] S_SCAN     = 2'd0;
   localparam logic [1:0] S_DEBOUNCE = 2'd1;
   localparam logic [1:0] S_PRESSED  = 2'd2;
   localparam logic [1:0] S_RELEASE  = 2'd3;

   // Out-of-range parameters are rejected at elaboration
   if (TICK_CYCLES < 1 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
   begin : g_param_check
      $error("keypad_scan_entry: parameter out of range");
   end

   logic [DIV_W-1:0] div;
   logic             tick;
   logic [3:0]       row_meta;
   logic [3:0]       rs;
   logic [1:0]       state;
   logic [1:0]       col_idx;
   logic [1:0]       key_row;
   logic [1:0]       row_idx;
   logic [3:0]       deb_cnt;
   logic             single;
   logic             same_key;
   logic [3:0]       code;

`ifdef KEY_REPEAT_EN
   localparam int             REP_W      = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
   logic [REP_W-1:0] rep_cnt;
`endif

   // Row/column position to hex legend of the keypad
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0:    key_map = 4'h1;
         4'h1:    key_map = 4'h2;
         4'h2:    key_map = 4'h3;
         4'h3:    key_map = 4'hA;
         4'h4:    key_map = 4'h4;
         4'h5:    key_map = 4'h5;
         4'h6:    key_map = 4'h6;
         4'h7:    key_map = 4'hB;
         4'h8:    key_map = 4'h7;
         4'h9:    key_map = 4'h8;
         4'hA:    key_map = 4'h9;
         4'hB:    key_map = 4'hC;
         4'hC:    key_map = 4'hE;
         4'hD:    key_map = 4'h0;
         4'hE:    key_map = 4'hF;
         default: key_map = 4'hD;
      endcase
   endfunction

   // Scan tick divider: one-cycle tick on the last count, then wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div <= '0;
      else if (tick) div <= '0;
      else           div <= div + 1'b1;
   end

   assign tick = (div == TICK_LAST);

   // Two-flop synchronizer for the asynchronous row returns (idle high)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'b1111;
         rs       <= 4'b1111;
      end else begin
         row_meta <= row;
         rs       <= row_meta;
      end
   end

   // Exactly one row low is a usable key; anything else is idle or ghosting
   always_comb begin
      single  = 1'b1;
      row_idx = 2'd0;
      case (rs)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: single  = 1'b0;
      endcase
   end

   assign same_key  = single && (row_idx == key_row);
   assign code      = key_map(key_row, col_idx);
   assign col       = ~(4'b0001 << col_idx);
   assign key_valid = (state == S_PRESSED);

   // Scan / debounce / accept / release sequencing; column frozen while a key is tracked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_SCAN;
         col_idx <= 2'd0;
         key_row <= 2'd0;
         deb_cnt <= 4'd0;
`ifdef KEY_REPEAT_EN
         rep_cnt <= '0;
`endif
      end else begin
         case (state)
            S_SCAN: if (tick) begin
               if (single) begin
                  key_row <= row_idx;
                  if (DEBOUNCE_SCANS == 1) begin
                     state <= S_PRESSED;
                  end else begin
                     deb_cnt <= 4'd1;
                     state   <= S_DEBOUNCE;
                  end
               end else begin
                  col_idx <= col_idx + 2'd1;
               end
            end
            S_DEBOUNCE: if (tick) begin
               if (same_key) begin
                  deb_cnt <= deb_cnt + 4'd1;
                  if (deb_cnt + 4'd1 == DEB_TARGET) state <= S_PRESSED;
               end else begin
                  deb_cnt <= 4'd0;
                  state   <= S_SCAN;
                  col_idx <= col_idx + 2'd1;
               end
            end
            S_PRESSED: begin
               deb_cnt <= 4'd0;
               state   <= S_RELEASE;
`ifdef KEY_REPEAT_EN
               rep_cnt <= '0;
`endif
            end
            default: if (tick) begin
               if (rs == 4'b1111) begin
                  if (deb_cnt + 4'd1 == DEB_TARGET) begin
                     deb_cnt <= 4'd0;
                     state   <= S_SCAN;
                     col_idx <= col_idx + 2'd1;
                  end else begin
                     deb_cnt <= deb_cnt + 4'd1;
                  end
               end else begin
                  deb_cnt <= 4'd0;
               end
`ifdef KEY_REPEAT_EN
               // Held key: count ticks towards an auto-repeat accept
               if (same_key) begin
                  if (rep_cnt + 1'b1 == REP_TARGET) begin
                     rep_cnt <= '0;
                     deb_cnt <= 4'd0;
                     state   <= S_PRESSED;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end else begin
                  rep_cnt <= '0;
               end
`endif
            end
         endcase
      end
   end

   // Accepted key code and entry shift register; clear has priority over the shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code <= 4'h0;
         hex3     <= 4'h0;
         hex2     <= 4'h0;
         hex1     <= 4'h0;
         hex0     <= 4'h0;
      end else begin
         if (state == S_PRESSED) key_code <= code;
         if (clear) begin
            hex3 <= 4'h0;
            hex2 <= 4'h0;
            hex1 <= 4'h0;
            hex0 <= 4'h0;
         end else if (state == S_PRESSED) begin
            hex3 <= hex2;
            hex2 <= hex1;
            hex1 <= hex0;
            hex0 <= code;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_entry.sv
//==========================================================================
// Module   : tb_keypad_scan_entry
// Desc     : Directed bench for keypad_scan_entry with a behavioural 4x4
//            keypad (row follows the strobed column of the held key).
// Revision : 1.0  initial release
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scan_entry;

   localparam int TICK_CYCLES    = 4;
   localparam int DEBOUNCE_SCANS = 3;
   localparam int REPEAT_SCANS   = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] hex3, hex2, hex1, hex0;

   logic       key_down  = 1'b0;
   logic [1:0] kr        = 2'd0;
   logic [1:0] kc        = 2'd0;
   logic       force_en  = 1'b0;
   logic [3:0] force_val = 4'hF;

   int compared   = 0;
   int mismatched = 0;
   int pulses     = 0;
   int ntick      = 0;
   logic [1:0] phase;

   keypad_scan_entry #(
      .TICK_CYCLES   (TICK_CYCLES),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
      .REPEAT_SCANS  (REPEAT_SCANS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .row      (row),
      .col      (col),
      .key_valid(key_valid),
      .key_code (key_code),
      .hex3     (hex3),
      .hex2     (hex2),
      .hex1     (hex1),
      .hex0     (hex0)
   );

   always #5 clk = ~clk;

   // Keypad: the held key pulls its row low only while its column is strobed
   assign row = force_en ? force_val :
                ((key_down && (col[kc] == 1'b0)) ? ~(4'b0001 << kr) : 4'b1111);

   // Expected scan-tick timing: every 4th edge after reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase <= 2'd0;
      else if (phase == 2'd3) begin
         phase <= 2'd0;
         ntick <= ntick + 1;
      end else phase <= phase + 2'd1;
   end

   // Count KeyValid pulses
   always @(negedge clk) if (rst_n && key_valid === 1'b1) pulses <= pulses + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_col_change(output int n);
      logic [3:0] c0;
      c0 = col;
      n  = 0;
      while (col === c0 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_col_enter(input logic [3:0] target);
      int n;
      n = 0;
      while (col === target && n < 50) begin @(negedge clk); n++; end
      while (col !== target && n < 50) begin @(negedge clk); n++; end
      check("col enter", 16'(n < 50), 16'h1);
   endtask

   task automatic wait_ticks(input int n);
      int t0;
      t0 = ntick;
      while (ntick < t0 + n) @(negedge clk);
   endtask

   task automatic wait_pulse(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic press_key(input logic [1:0] r, input logic [1:0] c,
                            input logic [3:0] code, input string tag);
      bit seen;
      int n;
      kr = r;
      kc = c;
      key_down = 1'b1;
      wait_pulse(seen);
      key_down = 1'b0;
      check({tag, " pulse"}, 16'(seen), 16'h1);
      @(negedge clk);
      check({tag, " code"}, 16'(key_code), 16'(code));
      check({tag, " one-cycle"}, 16'(key_valid), 16'h0);
      wait_col_change(n);
   endtask

   initial begin
      bit         seen;
      int         n;
      int         p0;
      logic [3:0] c0;

      // ---- reset and idle scanning
      repeat (3) @(negedge clk);
      check("reset col", 16'(col), 16'hE);
      check("reset keyvalid", 16'(key_valid), 16'h0);
      check("reset keycode", 16'(key_code), 16'h0);
      check("reset hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      rst_n = 1'b1;
      wait_col_change(n);
      check("idle first rotate time", 16'(n), 16'd4);
      check("idle col1", 16'(col), 16'hD);
      wait_col_change(n);
      check("idle period", 16'(n), 16'd4);
      check("idle col2", 16'(col), 16'hB);
      wait_col_change(n);
      check("idle col3", 16'(col), 16'h7);
      wait_col_change(n);
      check("idle wrap col0", 16'(col), 16'hE);
      check("idle no pulses", 16'(pulses), 16'h0);
      check("idle hex", {hex3, hex2, hex1, hex0}, 16'h0000);

      // ---- key 6 (r1,c2) held for about 20 ticks
      kr = 2'd1;
      kc = 2'd2;
      key_down = 1'b1;
      wait_pulse(seen);
      check("k6 pulse", 16'(seen), 16'h1);
      check("k6 col frozen", 16'(col), 16'hB);
      @(negedge clk);
      check("k6 keycode", 16'(key_code), 16'h6);
      check("k6 hex0", 16'(hex0), 16'h6);
      wait_ticks(17);
      check("k6 col held", 16'(col), 16'hB);
`ifdef KEY_REPEAT_EN
      check("k6 pulses while held", 16'(pulses), 16'd4);
`else
      check("k6 pulses while held", 16'(pulses), 16'd1);
`endif
      key_down = 1'b0;
      repeat (8) @(negedge clk);
      check("k6 col before 3 idle ticks", 16'(col), 16'hB);
      wait_col_change(n);
      check("k6 release time", 16'(n), 16'd4);
      check("k6 col after release", 16'(col), 16'h7);

      // ---- sequential entry 1, A, 0, D, 5
      p0 = pulses;
      press_key(2'd0, 2'd0, 4'h1, "k1");
      press_key(2'd0, 2'd3, 4'hA, "kA");
      press_key(2'd3, 2'd1, 4'h0, "k0");
      press_key(2'd3, 2'd3, 4'hD, "kD");
      press_key(2'd1, 2'd1, 4'h5, "k5");
      check("entry pulses", 16'(pulses - p0), 16'd5);
      check("entry hex", {hex3, hex2, hex1, hex0}, 16'hA0D5);

      // ---- bouncing key 7 (r2,c0): 2 stable ticks, 1 idle, then stable again
      p0 = pulses;
      kr = 2'd2;
      kc = 2'd0;
      wait_col_enter(4'b1110);
      key_down = 1'b1;
      wait_ticks(2);
      key_down = 1'b0;
      wait_ticks(1);
      check("bounce no early accept", 16'(pulses - p0), 16'd0);
      key_down = 1'b1;
      wait_pulse(seen);
      key_down = 1'b0;
      check("bounce pulse", 16'(seen), 16'h1);
      @(negedge clk);
      check("bounce keycode", 16'(key_code), 16'h7);
      check("bounce hex", {hex3, hex2, hex1, hex0}, 16'h0D57);
      check("bounce pulse count", 16'(pulses - p0), 16'd1);
      wait_col_change(n);

      // ---- ghosting: rows 0 and 2 low together
      p0 = pulses;
      force_val = 4'b1010;
      force_en  = 1'b1;
      wait_ticks(1);
      c0 = col;
      wait_ticks(1);
      check("ghost rotate a", 16'(col), 16'({c0[2:0], c0[3]}));
      c0 = col;
      wait_ticks(1);
      check("ghost rotate b", 16'(col), 16'({c0[2:0], c0[3]}));
      check("ghost no accept", 16'(pulses - p0), 16'd0);
      force_en = 1'b0;

      // ---- clear in the PRESSED cycle of key 9 (r2,c2)
      kr = 2'd2;
      kc = 2'd2;
      key_down = 1'b1;
      wait_pulse(seen);
      clear    = 1'b1;
      key_down = 1'b0;
      check("clear pulse", 16'(seen), 16'h1);
      @(negedge clk);
      clear = 1'b0;
      check("clear hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      check("clear keycode", 16'(key_code), 16'h9);
      wait_col_change(n);

      // ---- reset during debounce of key 2 (r0,c1)
      press_key(2'd0, 2'd2, 4'h3, "k3");
      check("k3 hex", {hex3, hex2, hex1, hex0}, 16'h0003);
      kr = 2'd0;
      kc = 2'd1;
      wait_col_enter(4'b1101);
      key_down = 1'b1;
      wait_ticks(2);
      p0 = pulses;
      rst_n = 1'b0;
      #1;
      check("midreset col", 16'(col), 16'hE);
      check("midreset keyvalid", 16'(key_valid), 16'h0);
      check("midreset keycode", 16'(key_code), 16'h0);
      check("midreset hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      key_down = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(6);
      check("midreset no pulse", 16'(pulses - p0), 16'd0);
      check("midreset keycode after", 16'(key_code), 16'h0);

`ifdef KEY_REPEAT_EN
      // ---- auto-repeat: key D held 3+5+5 ticks
      kr = 2'd3;
      kc = 2'd3;
      wait_col_enter(4'b0111);
      p0 = pulses;
      key_down = 1'b1;
      wait_ticks(13);
      key_down = 1'b0;
      wait_ticks(6);
      check("repeat pulses", 16'(pulses - p0), 16'd3);
      check("repeat hex", {hex3, hex2, hex1, hex0}, 16'h0DDD);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
